// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the MIPS debug/state-dump logic: stream beat kinds
// and the dumper FSM state encoding.
package mips_dbg_pkg;

  localparam logic [1:0] DK_PC  = 2'd0;
  localparam logic [1:0] DK_REG = 2'd1;
  localparam logic [1:0] DK_MEM = 2'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HALT     = 3'd1,
    PC       = 3'd2,
    REG      = 3'd3,
    MEM_RD   = 3'd4,
    MEM_WAIT = 3'd5,
    FIN      = 3'd6
  } dump_state_e;

endpackage

// File: rtl/mips_byte_word_assembler.sv
// Big-endian byte-to-word assembler: the first byte of a group lands in the
// most significant byte; word_valid flags the byte that completes the word.
module mips_byte_word_assembler #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_valid
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_byte_valid) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  generate
    if (BYTES > 1) begin : g_multi
      // Only the bytes received so far are stored; the word is completed
      // combinationally by the incoming byte so it can be captured that cycle.
      logic [DATA_W-9:0] r_low;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_low <= '0;
        end else if (i_byte_valid) begin
          r_low <= w_next[DATA_W-9:0];
        end
      end
      assign w_next = {r_low, i_byte};
    end else begin : g_single
      assign w_next = i_byte;
    end
  endgenerate

  assign o_word       = w_next;
  assign o_word_valid = i_byte_valid && (r_cnt == LAST);

endmodule

// File: rtl/mips_state_dump.sv
// End-of-run state dumper: halts the core, then streams PC, register file and
// a data-memory window as {kind, index, data} beats over valid/ready.
module mips_state_dump
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 32,
  parameter int RF_IDX_W   = 5,
  parameter int MEM_ADDR_W = 10,
  parameter int MEM_BASE   = 0,
  parameter int MEM_WORDS  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_halt_req,
  input  logic                  cpu_halted,
  input  logic [DATA_W-1:0]     pc,
  output logic [RF_IDX_W-1:0]   rf_raddr,
  input  logic [DATA_W-1:0]     rf_rdata,
  output logic                  dm_ren,
  output logic [MEM_ADDR_W-1:0] dm_raddr,
  input  logic [7:0]            dm_rdata,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [1:0]            dump_kind,
  output logic [15:0]           dump_index,
  output logic [DATA_W-1:0]     dump_data
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]      LAST_BYTE  = CNT_W'(BYTES - 1);
  localparam logic [15:0]           LAST_REG   = 16'(NUM_REGS - 1);
  localparam logic [15:0]           LAST_MEM   = 16'(MEM_WORDS - 1);
  localparam logic [MEM_ADDR_W-1:0] MEM_BASE_A = MEM_ADDR_W'(MEM_BASE);

  dump_state_e           r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_halt_req;
  logic                  r_dm_ren;
  logic                  r_rd_pend;
  logic                  r_valid;
  logic [1:0]            r_kind;
  logic [15:0]           r_index;
  logic [15:0]           r_idx;
  logic [DATA_W-1:0]     r_data;
  logic [RF_IDX_W-1:0]   r_rf_raddr;
  logic [MEM_ADDR_W-1:0] r_dm_raddr;
  logic [CNT_W-1:0]      r_rd_cnt;

  logic                  w_xfer;
  logic                  w_asm_clr;
  logic                  w_word_valid;
  logic [DATA_W-1:0]     w_word;

  assign w_xfer    = r_valid && dump_ready;
  assign w_asm_clr = (r_state == IDLE);

  mips_byte_word_assembler #(
    .DATA_W (DATA_W)
  ) u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_asm_clr),
    .i_byte_valid (r_rd_pend),
    .i_byte       (dm_rdata),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_halt_req <= 1'b0;
      r_dm_ren   <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_valid    <= 1'b0;
      r_kind     <= 2'd0;
      r_index    <= 16'd0;
      r_idx      <= 16'd0;
      r_data     <= '0;
      r_rf_raddr <= '0;
      r_dm_raddr <= '0;
      r_rd_cnt   <= '0;
    end else begin
      // Memory read data arrives one cycle after the enable.
      r_rd_pend <= r_dm_ren;
      r_done    <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= HALT;
            r_busy     <= 1'b1;
            r_halt_req <= 1'b1;
          end
        end

        HALT: begin
          if (cpu_halted) begin
            r_state <= PC;
            r_valid <= 1'b1;
            r_kind  <= DK_PC;
            r_index <= 16'd0;
            r_data  <= pc;
          end
        end

        PC: begin
          if (w_xfer) begin
            r_valid    <= 1'b0;
            r_state    <= REG;
            r_idx      <= 16'd0;
            r_rf_raddr <= '0;
          end
        end

        // First cycle samples the combinational register read, second onward
        // presents the beat until it is accepted.
        REG: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_kind  <= DK_REG;
            r_index <= r_idx;
            r_data  <= rf_rdata;
          end else if (w_xfer) begin
            r_valid <= 1'b0;
            if (r_idx != LAST_REG) begin
              r_idx      <= r_idx + 16'd1;
              r_rf_raddr <= r_rf_raddr + 1'b1;
            end else if (MEM_WORDS == 0) begin
              r_state    <= FIN;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_halt_req <= 1'b0;
            end else begin
              r_state    <= MEM_RD;
              r_idx      <= 16'd0;
              r_dm_ren   <= 1'b1;
              r_dm_raddr <= MEM_BASE_A;
              r_rd_cnt   <= '0;
            end
          end
        end

        MEM_RD: begin
          if (r_rd_cnt == LAST_BYTE) begin
            r_dm_ren <= 1'b0;
            r_state  <= MEM_WAIT;
          end else begin
            r_dm_raddr <= r_dm_raddr + 1'b1;
            r_rd_cnt   <= r_rd_cnt + 1'b1;
          end
        end

        MEM_WAIT: begin
          if (!r_valid) begin
            if (w_word_valid) begin
              r_valid <= 1'b1;
              r_kind  <= DK_MEM;
              r_index <= r_idx;
              r_data  <= w_word;
            end
          end else if (w_xfer) begin
            r_valid <= 1'b0;
            if (r_idx == LAST_MEM) begin
              r_state    <= FIN;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_halt_req <= 1'b0;
            end else begin
              // The next word begins right after the last byte read; the
              // address counter wraps naturally at the memory size.
              r_state    <= MEM_RD;
              r_idx      <= r_idx + 16'd1;
              r_dm_ren   <= 1'b1;
              r_dm_raddr <= r_dm_raddr + 1'b1;
              r_rd_cnt   <= '0;
            end
          end
        end

        FIN: begin
          r_state    <= IDLE;
          r_rf_raddr <= '0;
          r_dm_raddr <= '0;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign cpu_halt_req = r_halt_req;
  assign rf_raddr     = r_rf_raddr;
  assign dm_ren       = r_dm_ren;
  assign dm_raddr     = r_dm_raddr;
  assign dump_valid   = r_valid;
  assign dump_kind    = r_kind;
  assign dump_index   = r_index;
  assign dump_data    = r_data;

endmodule

// File: tb/tb_mips_state_dump.sv
// Scoreboard bench for mips_state_dump: default, wrapping-window and
// register-only configurations driven with directed vectors.
`timescale 1ns/1ps
module tb_mips_state_dump;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] idx;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- default configuration ----------------
  logic m_start = 1'b0, m_halted = 1'b1, m_ready = 1'b1, m_bp_en = 1'b0;
  logic m_busy, m_done, m_halt_req, m_dm_ren, m_valid;
  logic [4:0]  m_rf_raddr;
  logic [31:0] m_rf_rdata, m_data;
  logic [31:0] m_pc = 32'h0000_0040;
  logic [9:0]  m_dm_raddr;
  logic [7:0]  m_dm_rdata = 8'h00;
  logic [1:0]  m_kind;
  logic [15:0] m_index;
  logic [31:0] rf [32];
  logic [7:0]  dmem [1024];

  assign m_rf_rdata = rf[m_rf_raddr];
  always @(posedge clk) if (m_dm_ren) m_dm_rdata <= dmem[m_dm_raddr];

  mips_state_dump u_main (
    .clk(clk), .rst_n(rst_n), .start(m_start), .busy(m_busy), .done(m_done),
    .cpu_halt_req(m_halt_req), .cpu_halted(m_halted), .pc(m_pc),
    .rf_raddr(m_rf_raddr), .rf_rdata(m_rf_rdata), .dm_ren(m_dm_ren),
    .dm_raddr(m_dm_raddr), .dm_rdata(m_dm_rdata), .dump_valid(m_valid),
    .dump_ready(m_ready), .dump_kind(m_kind), .dump_index(m_index), .dump_data(m_data)
  );

  // ---------------- wrapping memory window ----------------
  logic w_start = 1'b0, w_halted = 1'b1, w_ready = 1'b1;
  logic w_busy, w_done, w_halt_req, w_dm_ren, w_valid;
  logic [4:0]  w_rf_raddr;
  logic [31:0] w_rf_rdata, w_data;
  logic [31:0] w_pc = 32'h0000_0100;
  logic [9:0]  w_dm_raddr;
  logic [7:0]  w_dm_rdata = 8'h00;
  logic [1:0]  w_kind;
  logic [15:0] w_index;

  assign w_rf_rdata = 32'h0000_0077 ^ {27'd0, w_rf_raddr};
  always @(posedge clk) if (w_dm_ren) w_dm_rdata <= w_dm_raddr[7:0] ^ 8'h5A;

  mips_state_dump #(.NUM_REGS(1), .MEM_BASE('h3F8), .MEM_WORDS(3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(w_start), .busy(w_busy), .done(w_done),
    .cpu_halt_req(w_halt_req), .cpu_halted(w_halted), .pc(w_pc),
    .rf_raddr(w_rf_raddr), .rf_rdata(w_rf_rdata), .dm_ren(w_dm_ren),
    .dm_raddr(w_dm_raddr), .dm_rdata(w_dm_rdata), .dump_valid(w_valid),
    .dump_ready(w_ready), .dump_kind(w_kind), .dump_index(w_index), .dump_data(w_data)
  );

  // ---------------- registers only, no memory words ----------------
  logic s_start = 1'b0, s_halted = 1'b1, s_ready = 1'b1;
  logic s_busy, s_done, s_halt_req, s_dm_ren, s_valid;
  logic [4:0]  s_rf_raddr;
  logic [31:0] s_rf_rdata, s_data;
  logic [31:0] s_pc = 32'h0000_0200;
  logic [9:0]  s_dm_raddr;
  logic [7:0]  s_dm_rdata = 8'h00;
  logic [1:0]  s_kind;
  logic [15:0] s_index;

  assign s_rf_rdata = 32'hA000_0000 | {27'd0, s_rf_raddr};

  mips_state_dump #(.NUM_REGS(4), .MEM_WORDS(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .cpu_halt_req(s_halt_req), .cpu_halted(s_halted), .pc(s_pc),
    .rf_raddr(s_rf_raddr), .rf_rdata(s_rf_rdata), .dm_ren(s_dm_ren),
    .dm_raddr(s_dm_raddr), .dm_rdata(s_dm_rdata), .dump_valid(s_valid),
    .dump_ready(s_ready), .dump_kind(s_kind), .dump_index(s_index), .dump_data(s_data)
  );

  // ---------------- ready driver (backpressure: ready high ~30%) ----------------
  initial forever begin
    @(posedge clk);
    #1 m_ready = m_bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // ---------------- monitors ----------------
  beat_t m_exp_q[$];
  beat_t m_got, m_exp, m_stall_beat;
  logic  m_stall_prev = 1'b0;
  int    m_beats = 0, m_done_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_stall_prev = 1'b0;
    end else begin
      m_got = {m_kind, m_index, m_data};
      if (m_stall_prev) chk("main_stall_hold", {m_valid, m_got}, {1'b1, m_stall_beat});
      if (m_valid && m_ready) begin
        $display("main beat %0d: kind=%0d index=%0d data=%h", m_beats, m_kind, m_index, m_data);
        if (m_exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL main_extra_beat: got 0x%0h, no beat expected", m_got);
        end else begin
          m_exp = m_exp_q.pop_front();
          chk("main_beat", m_got, m_exp);
        end
        if (m_beats == 0)  chk("main_beat0_pc", m_got, {2'd0, 16'd0, 32'h0000_0040});
        if (m_beats == 9)  chk("main_beat9_t0", m_got, {2'd1, 16'd8, 32'hDEAD_BEEF});
        if (m_beats == 33) chk("main_beat33_mem0", m_got, {2'd2, 16'd0, 32'h1234_5678});
        m_beats++;
      end
      m_stall_prev = m_valid && !m_ready;
      m_stall_beat = m_got;
      if (m_done) begin
        m_done_cnt++;
        $display("main done after %0d beats", m_beats);
        chk("main_done_release", {m_busy, m_halt_req}, 2'b00);
        chk("main_done_last", m_exp_q.size(), 0);
      end
    end
  end

  beat_t w_exp_q[$];
  logic [9:0] w_addr_q[$];
  beat_t w_got;
  int w_beats = 0, w_done_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (w_dm_ren) begin
        if (w_addr_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL wrap_extra_read: got addr 0x%0h, none expected", w_dm_raddr);
        end else begin
          chk("wrap_addr", w_dm_raddr, w_addr_q.pop_front());
        end
      end
      if (w_valid && w_ready) begin
        w_got = {w_kind, w_index, w_data};
        $display("wrap beat %0d: kind=%0d index=%0d data=%h", w_beats, w_kind, w_index, w_data);
        if (w_exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL wrap_extra_beat: got 0x%0h, no beat expected", w_got);
        end else begin
          chk("wrap_beat", w_got, w_exp_q.pop_front());
        end
        w_beats++;
      end
      if (w_done) begin
        w_done_cnt++;
        chk("wrap_done_release", {w_busy, w_halt_req}, 2'b00);
      end
    end
  end

  beat_t s_exp_q[$];
  beat_t s_got;
  int s_beats = 0, s_done_cnt = 0, s_last_xfer = 0;
  logic s_ren_seen = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (s_dm_ren) s_ren_seen = 1'b1;
      if (s_valid && s_ready) begin
        s_got = {s_kind, s_index, s_data};
        $display("small beat %0d: kind=%0d index=%0d data=%h", s_beats, s_kind, s_index, s_data);
        if (s_exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL small_extra_beat: got 0x%0h, no beat expected", s_got);
        end else begin
          chk("small_beat", s_got, s_exp_q.pop_front());
        end
        s_beats++;
        s_last_xfer = cyc;
      end
      if (s_done) begin
        s_done_cnt++;
        chk("small_done_latency", cyc - s_last_xfer, 1);
        chk("small_done_release", {s_busy, s_halt_req, s_exp_q.size() == 0}, 3'b001);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input int which);
    @(posedge clk);
    #1;
    case (which)
      0: m_start = 1'b1;
      1: w_start = 1'b1;
      default: s_start = 1'b1;
    endcase
    @(posedge clk);
    #1;
    m_start = 1'b0; w_start = 1'b0; s_start = 1'b0;
  endtask

  function automatic int done_count(input int which);
    case (which)
      0: return m_done_cnt;
      1: return w_done_cnt;
      default: return s_done_cnt;
    endcase
  endfunction

  task automatic wait_done(input int which, input string name, input int budget);
    int d0, c;
    d0 = done_count(which);
    c = 0;
    while (done_count(which) == d0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk(name, done_count(which) - d0, 1);
  endtask

  task automatic push_main();
    m_exp_q.push_back({2'd0, 16'd0, m_pc});
    for (int i = 0; i < 32; i++) m_exp_q.push_back({2'd1, 16'(i), rf[i]});
    for (int k = 0; k < 12; k++)
      m_exp_q.push_back({2'd2, 16'(k), dmem[4*k], dmem[4*k+1], dmem[4*k+2], dmem[4*k+3]});
  endtask

  task automatic chk_main_idle(input string name);
    chk(name, {m_busy, m_done, m_halt_req, m_dm_ren, m_valid, m_rf_raddr, m_dm_raddr}, 0);
    chk({name, "_payload"}, {m_kind, m_index, m_data}, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int found, c, d0;
    for (int i = 0; i < 32; i++) rf[i] = 32'hC0DE_0000 | (i * 3);
    rf[8] = 32'hDEAD_BEEF;
    for (int a = 0; a < 1024; a++) dmem[a] = 8'(a) ^ 8'h3C;
    dmem[0] = 8'h12; dmem[1] = 8'h34; dmem[2] = 8'h56; dmem[3] = 8'h78;

    #2 rst_n = 1'b0;
    #1;
    chk_main_idle("main_reset");
    chk("wrap_reset", {w_busy, w_done, w_halt_req, w_dm_ren, w_valid, w_kind, w_index, w_data}, 0);
    chk("small_reset", {s_busy, s_done, s_halt_req, s_dm_ren, s_valid, s_kind, s_index, s_data}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // full-throughput dump
    m_beats = 0; push_main(); pulse(0);
    chk("main_busy_on_start", {m_busy, m_halt_req}, 2'b11);
    wait_done(0, "main_run1_done", 1000);
    chk("main_run1_beats", m_beats, 45);
    repeat (5) @(posedge clk);
    chk("main_run1_single_done", m_done_cnt, 1);

    // halt acknowledge delayed 7 cycles, then dropped mid-dump
    m_halted = 1'b0; m_beats = 0; push_main(); pulse(0);
    repeat (7) begin
      @(negedge clk);
      chk("main_halt_wait", {m_valid, m_dm_ren, m_rf_raddr, m_halt_req, m_busy}, {2'b00, 5'd0, 2'b11});
    end
    @(posedge clk); #1 m_halted = 1'b1;
    repeat (40) @(posedge clk);
    #1 m_halted = 1'b0;
    wait_done(0, "main_run2_done", 1000);
    m_halted = 1'b1;
    chk("main_run2_beats", m_beats, 45);

    // random backpressure, with a start pulse while busy
    m_bp_en = 1'b1; m_beats = 0; push_main(); pulse(0);
    repeat (30) @(posedge clk);
    pulse(0);
    wait_done(0, "main_bp_done", 5000);
    m_bp_en = 1'b0;
    chk("main_bp_beats", m_beats, 45);
    repeat (10) @(posedge clk);
    #1 chk("main_ignored_start", m_busy, 1'b0);

    // asynchronous reset during MEM 2
    m_beats = 0; push_main(); pulse(0);
    found = 0; c = 0;
    while (!found && c < 1000) begin
      @(negedge clk);
      c++;
      if (m_dm_ren && m_dm_raddr == 10'd8) found = 1;
    end
    chk("main_reached_mem2", found, 1);
    d0 = m_done_cnt;
    #2 rst_n = 1'b0;
    #1 chk_main_idle("main_async_reset");
    m_exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("main_no_done_on_reset", m_done_cnt, d0);

    // fresh dump after the abort
    m_beats = 0; push_main(); pulse(0);
    wait_done(0, "main_run5_done", 1000);
    chk("main_run5_beats", m_beats, 45);

    // window wrapping past the top of data memory
    w_exp_q.push_back({2'd0, 16'd0, 32'h0000_0100});
    w_exp_q.push_back({2'd1, 16'd0, 32'h0000_0077});
    w_exp_q.push_back({2'd2, 16'd0, 32'hA2A3_A0A1});
    w_exp_q.push_back({2'd2, 16'd1, 32'hA6A7_A4A5});
    w_exp_q.push_back({2'd2, 16'd2, 32'h5A5B_5859});
    for (int i = 0; i < 12; i++) w_addr_q.push_back(10'((32'h3F8 + i) & 32'h3FF));
    pulse(1);
    wait_done(1, "wrap_done", 1000);
    chk("wrap_beats", w_beats, 5);
    chk("wrap_addr_drain", w_addr_q.size(), 0);

    // registers only
    s_exp_q.push_back({2'd0, 16'd0, 32'h0000_0200});
    for (int i = 0; i < 4; i++) s_exp_q.push_back({2'd1, 16'(i), 32'hA000_0000 | i});
    pulse(2);
    wait_done(2, "small_done", 1000);
    repeat (5) @(posedge clk);
    chk("small_beats", s_beats, 5);
    chk("small_no_dm_ren", s_ren_seen, 1'b0);
    chk("small_single_done", s_done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_state_dump.md
Name: mips_state_dump

Overview:
- Synthesizable end-of-run state dumper for the single-cycle MIPS core; the hardware successor to the simulation-only final dump.
- On request, halts the CPU, then streams out the PC, the register file and a parametrised data-memory window over a valid/ready channel.
- Sits beside the MIPS top, with read-only taps into the PC, the register file and the data memory. Feeds a UART/trace sink or a bench monitor.

Parameters:
- DATA_W, 32, architectural word width; must be a multiple of 8.
- NUM_REGS, 32, number of register-file entries dumped (1..32).
- RF_IDX_W, 5, register index width.
- MEM_ADDR_W, 10, data-memory byte-address width.
- MEM_BASE, 0, byte address of the first dumped word; must be 4-aligned.
- MEM_WORDS, 12, number of memory words dumped (0 allowed).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that requests a dump.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.
- cpu_halt_req  out  1  freeze request to the core.
- cpu_halted  in  1  core acknowledges it is frozen.
- pc  in  DATA_W  current PC.
- rf_raddr  out  RF_IDX_W  register-file debug read address; read data is combinational.
- rf_rdata  in  DATA_W  register-file debug read data.
- dm_ren  out  1  data-memory byte read enable.
- dm_raddr  out  MEM_ADDR_W  data-memory byte address.
- dm_rdata  in  8  byte read data, valid the cycle after dm_ren.
- dump_valid  out  1  stream valid.
- dump_ready  in  1  stream ready.
- dump_kind  out  2  0 = PC, 1 = register, 2 = memory.
- dump_index  out  16  register number or memory word index k.
- dump_data  out  DATA_W  beat payload.

Behaviour:
- Reset (asynchronous): state IDLE; busy, done, cpu_halt_req, dm_ren and dump_valid all 0; dump_kind, dump_index, dump_data, rf_raddr and dm_raddr all 0.
- IDLE: start=1 moves to HALT and sets busy=1 on the next edge. start while busy is ignored.
- HALT: cpu_halt_req=1 and is held until done. The FSM waits for cpu_halted=1, with no timeout.
- PC: presents the beat {kind 0, index 0, data pc} captured on entry.
- REG i (i = 0..NUM_REGS-1):
  - rf_raddr=i; rf_rdata is registered into dump_data; beat {1, i}.
  - Register 0 is dumped as read, not forced to zero.
- MEM k (k = 0..MEM_WORDS-1):
  - Issues 4 consecutive byte reads with dm_ren=1 at addresses MEM_BASE+4k+0..3, one per cycle.
  - Addresses wrap modulo 2^MEM_ADDR_W.
  - Assembles the word big-endian: byte +0 goes to dump_data[31:24].
  - Beat {2, k} is presented the cycle after the 4th byte returns, so latency is 5 cycles per word before valid.
- Handshake:
  - A beat transfers on dump_valid && dump_ready.
  - While valid && !ready, kind, index and data are held stable and no new reads are issued.
  - dump_valid never drops without a transfer.
  - At most one beat is outstanding; no skid buffer.
- Sequencing: after each transfer, advance PC → REG 0 … REG NUM_REGS-1 → MEM 0 … MEM MEM_WORDS-1 → FIN. MEM_WORDS=0 goes straight from the last REG to FIN.
- FIN: done=1 for one cycle, busy=0 and cpu_halt_req=0 in the same cycle, then return to IDLE.
- Total beats = 1 + NUM_REGS + MEM_WORDS.
- Reset mid-dump aborts immediately: halt released, no done pulse, any partial beat discarded.
- cpu_halted dropping mid-dump is ignored; the dump continues.

Decomposition:
- Shared package mips_dbg_pkg holds:
  - the dump_kind encoding constants (DK_PC, DK_REG, DK_MEM);
  - the FSM state enum (IDLE, HALT, PC, REG, MEM_RD, MEM_WAIT, FIN).
- One natural sub-module, mips_byte_word_assembler:
  - 4-beat byte-to-word big-endian shifter with a byte counter and a word_valid output;
  - reusable by a future memory loader.

Test Plan:
- Reset, then start with cpu_halted tied 1 and dump_ready=1. Preload PC=0x0000_0040, $t0=0xDEAD_BEEF, DataMemory[0..3]=12 34 56 78. Required:
  - 45 beats;
  - beat 0 = {0, 0, 0x40};
  - beat 9 = {1, 8, 0xDEADBEEF};
  - beat 33 = {2, 0, 0x12345678};
  - done pulses once; cpu_halt_req falls with done.
- Delay cpu_halted by 7 cycles: no dump_valid before cpu_halted; dm_ren and rf_raddr stay idle.
- Random dump_ready backpressure at 30% duty: payload stable while stalled; the beat sequence is identical to the full-throughput run.
- MEM_BASE=0x3F8, MEM_ADDR_W=10, MEM_WORDS=3: dm_raddr sequence is 0x3F8..0x3FF then 0x000..0x003, wrapping at 0x400.
- Assert rst_n low during MEM 2: all outputs return to reset values asynchronously, with no done pulse. A fresh start then produces the full sequence from the PC beat.
- MEM_WORDS=0, NUM_REGS=4: exactly 5 beats; done follows the acceptance of REG 3; dm_ren is never asserted.
